// File: rtl/led_flow_ctrl.sv
// led_flow_ctrl: debounced run/pause controller for a one-hot running light
// with selectable step rate, direction and rotate/bounce mode.
module led_flow_ctrl #(
  parameter int LED_NUM    = 8,
  parameter int CNT_WIDTH  = 32,
  parameter int PERIOD0    = 100_000_000,
  parameter int PERIOD1    = 50_000_000,
  parameter int PERIOD2    = 25_000_000,
  parameter int PERIOD3    = 12_500_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               button,
  input  logic [1:0]         freq_set,
  input  logic               dir_set,
  input  logic               mode_set,
  output logic [LED_NUM-1:0] led,
  output logic               running
);
  localparam int DW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state, state_nxt;
  logic s1, s2, deb, press, bdir, step, deb_fire, go_lsb;
  logic [DW-1:0] deb_cnt;
  logic [CNT_WIDTH-1:0] cnt, period_sel;
  assign deb_fire = (s2 != deb) && (deb_cnt == DW'(DEB_CYCLES - 1));
  assign running = (state == RUN);
  always_comb begin
    period_sel = freq_set[1] ? (freq_set[0] ? CNT_WIDTH'(PERIOD3) : CNT_WIDTH'(PERIOD2))
                             : (freq_set[0] ? CNT_WIDTH'(PERIOD1) : CNT_WIDTH'(PERIOD0));
    step       = running && (cnt >= period_sel - 1'b1);
    // bounce reverses only when sitting on the end LED it was heading for
    go_lsb     = mode_set ? (bdir ? !led[0] : led[LED_NUM-1]) : dir_set;
    state_nxt  = press ? ((state == RUN) ? PAUSE : RUN) : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      deb     <= 1'b0;
      deb_cnt <= '0;
      press   <= 1'b0;
    end else begin
      s1    <= button;
      s2    <= s1;
      press <= deb_fire && s2;
      if (s2 == deb) deb_cnt <= '0;
      else if (deb_fire) begin
        deb     <= s2;
        deb_cnt <= '0;
      end else deb_cnt <= deb_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      led   <= LED_NUM'(1);
      bdir  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (step) cnt <= '0;
      else if (running) cnt <= cnt + 1'b1;
      if (step) led <= go_lsb ? {led[0], led[LED_NUM-1:1]} : {led[LED_NUM-2:0], led[LED_NUM-1]};
      if (!mode_set) bdir <= dir_set;
      else if (step) bdir <= go_lsb;
    end
  end
endmodule

// File: tb/tb_led_flow_ctrl.sv
// tb_led_flow_ctrl: randomized run of led_flow_ctrl; a position/direction reference model
// predicts every output change and a negedge monitor checks them from a queue.
module tb_led_flow_ctrl;
  localparam int N = 8;
  localparam int DEB = 4;
  localparam int PER [4] = '{4, 8, 16, 32};
  typedef struct {int c; logic [N-1:0] l; logic r;} ev_t;
  logic clk, rst, button, dir_set, mode_set, running;
  logic [1:0] freq_set;
  logic [N-1:0] led;
  int checks = 0, errors = 0, cyc = 0;
  ev_t q[$];
  ev_t e;
  logic [N-1:0] exp_led = 8'h01, pl = 8'h01, l0;
  logic exp_run = 1'b0, pr = 1'b0;
  int pos = 0, cnt = 0, run_len = 0, st = 0, per;
  bit h1 = 0, h2 = 0, lvl = 0, pp = 0, bdir = 0, s2_now, stp;

  led_flow_ctrl #(.LED_NUM(N), .CNT_WIDTH(32), .PERIOD0(4), .PERIOD1(8), .PERIOD2(16),
                  .PERIOD3(32), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .button(button), .freq_set(freq_set), .dir_set(dir_set),
    .mode_set(mode_set), .led(led), .running(running));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic push_if_changed();
    logic [N-1:0] nl;
    logic nr;
    nl = N'(1 << pos);
    nr = (st == 1);
    if (nl != exp_led || nr != exp_run) begin
      q.push_back('{cyc, nl, nr});
      exp_led = nl;
      exp_run = nr;
    end
  endtask

  // reference model: st 0=idle 1=run 2=pause, pos = index of the lit LED
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos = 0; cnt = 0; run_len = 0; st = 0;
      h1 = 0; h2 = 0; lvl = 0; pp = 0; bdir = 0;
      push_if_changed();
    end else begin
      cyc++;
      per = PER[freq_set];
      stp = (st == 1) && (cnt >= per - 1);
      if (stp) begin
        if (!mode_set) pos = dir_set ? (pos + N - 1) % N : (pos + 1) % N;
        else begin
          if (!bdir && pos == N - 1) bdir = 1;
          else if (bdir && pos == 0) bdir = 0;
          pos += bdir ? -1 : 1;
        end
        cnt = 0;
      end else if (st == 1) cnt++;
      if (!mode_set) bdir = dir_set;
      if (pp) st = (st == 1) ? 2 : 1;
      pp = 0;
      s2_now = h2; h2 = h1; h1 = button;
      if (s2_now != lvl) begin
        run_len++;
        if (run_len == DEB) begin
          lvl = s2_now;
          run_len = 0;
          pp = lvl;
        end
      end else run_len = 0;
      push_if_changed();
    end
  end

  always @(negedge clk) begin
    if (led !== pl || running !== pr) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL change: unexpected led=%h running=%b at cycle %0d", led, running, cyc);
      end else begin
        e = q.pop_front();
        if (e.c != cyc || e.l !== led || e.r !== running) begin
          errors++;
          $display("FAIL change: got led=%h running=%b cyc=%0d, expected led=%h running=%b cyc=%0d",
                   led, running, cyc, e.l, e.r, e.c);
        end
      end
      checks++;
      if (!$onehot(led)) begin
        errors++;
        $display("FAIL onehot: got led=%h, expected exactly one bit set", led);
      end
      pl = led;
      pr = running;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cw(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi);
    button = 1;
    cw(hi);
    button = 0;
  endtask

  task automatic wait_led(input logic [N-1:0] v, input int limit);
    int k = 0;
    while (led !== v && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("wait_led", 32'(led), 32'(v));
  endtask

  task automatic ensure_running();
    button = 0;
    cw(12);
    if (!exp_run) begin
      pulse(6);
      cw(10);
    end
    chk("ensure_running", 32'(running), 32'd1);
  endtask

  initial begin
    rst = 0; button = 0; freq_set = 0; dir_set = 0; mode_set = 0;
    cw(3);
    chk("reset_led", 32'(led), 32'h01);
    chk("reset_running", 32'(running), 32'd0);
    rst = 1;
    cw(3);
    for (int i = 0; i < 5; i++) begin
      pulse(2);
      cw(3);
    end
    cw(10);
    chk("glitch_running", 32'(running), 32'd0);
    chk("glitch_led", 32'(led), 32'h01);
    button = 1;
    cw(6);
    chk("latency6", 32'(running), 32'd0);
    cw(1);
    chk("latency7", 32'(running), 32'd1);
    cw(3);
    button = 0;
    cw(40);
    wait_led(8'h08, 100);
    pulse(6);
    cw(100);
    chk("pause_running", 32'(running), 32'd0);
    chk("pause_led", 32'(led), 32'(exp_led));
    pulse(6);
    cw(30);
    ensure_running();
    mode_set = 1; freq_set = 1; dir_set = 0;
    cw(200);
    for (int i = 0; i < 25; i++) begin
      freq_set = 2'($urandom_range(0, 3));
      dir_set = 1'($urandom_range(0, 1));
      mode_set = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        pulse($urandom_range(1, 8));
        cw($urandom_range(1, 8));
      end
      cw($urandom_range(5, 50));
    end
    ensure_running();
    mode_set = 0; dir_set = 0; freq_set = 0;
    wait_led(8'h01, 100);
    dir_set = 1;
    cw(4);
    chk("rotate_dir_flip", 32'(led), 32'h80);
    freq_set = 3;
    l0 = led;
    for (int k = 0; k < 40 && led === l0; k++) @(negedge clk);
    l0 = led;
    cw(20);
    freq_set = 0;
    cw(1);
    chk("fast_step", 32'(led != l0), 32'd1);
    cw(13);
    @(posedge clk);
    #2 rst = 0;
    #1;
    chk("async_led", 32'(led), 32'h01);
    chk("async_running", 32'(running), 32'd0);
    cw(2);
    rst = 1;
    cw(40);
    chk("post_reset_led", 32'(led), 32'h01);
    chk("post_reset_running", 32'(running), 32'd0);
    cw(5);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end
endmodule
